// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and constants for the HI/LO multiply/divide unit
package muldiv_pkg;

    localparam int MD_DATA_W = 32;
    localparam int MD_ITER   = MD_DATA_W;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - one-bit-per-step shift-add multiply / restoring divide datapath
module muldiv_iter_core #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic           div_mode,
    input  logic [W-1:0]   opa,
    input  logic [W-1:0]   opb,
    output logic [2*W-1:0] acc_next
);

    // acc = {upper partial product | remainder, multiplier | dividend-to-quotient}
    logic [2*W-1:0] acc;
    logic [W-1:0]   opnd;
    logic [W:0]     sum;
    logic [W:0]     shifted;
    logic [W:0]     trial;

    always_comb begin
        sum      = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
        shifted  = {acc[2*W-1:W], acc[W-1]};
        trial    = shifted - {1'b0, opnd};
        acc_next = {sum, acc[W-1:1]};
        if (div_mode) begin
            // The remainder stays below the divisor, so trial[W] is a clean borrow flag.
            if (!trial[W]) begin
                acc_next = {trial[W-1:0], acc[W-2:0], 1'b1};
            end else begin
                acc_next = {shifted[W-1:0], acc[W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            opnd <= '0;
        end else if (load) begin
            acc  <= {{W{1'b0}}, opb};
            opnd <= opa;
        end else if (step) begin
            acc  <= acc_next;
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
module hilo_muldiv
    import muldiv_pkg::*;
#(
    parameter int DATA_W = MD_ITER
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic              mthi_i,
    input  logic              mtlo_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              div_zero_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              busy, accept, last_step;
    logic              signed_op, op_div, rs_neg, rt_neg;
    logic              is_div, neg_q, neg_r, div_zero;
    logic [DATA_W-1:0] rs_abs, rt_abs, rs_orig;
    logic [DATA_W-1:0] hi, lo, res_hi, res_lo, quo, rem;
    logic [2*DATA_W-1:0] acc_next, prod;

    assign busy      = (state == ST_RUN);
    assign accept    = start_i && !busy;
    assign last_step = busy && (cnt == LAST_CNT);

    assign signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign op_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign rs_neg    = signed_op && rs_data_i[DATA_W-1];
    assign rt_neg    = signed_op && rt_data_i[DATA_W-1];
    assign rs_abs    = rs_neg ? -rs_data_i : rs_data_i;
    assign rt_abs    = rt_neg ? -rt_data_i : rt_data_i;

    muldiv_iter_core #(.W(DATA_W)) u_core (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (accept),
        .step     (busy),
        .div_mode (is_div),
        .opa      (rt_abs),
        .opb      (rs_abs),
        .acc_next (acc_next)
    );

    // Commit uses the core's final step combinationally so HI/LO update at the 32nd edge.
    assign prod = neg_q ? -acc_next : acc_next;
    assign quo  = acc_next[DATA_W-1:0];
    assign rem  = acc_next[2*DATA_W-1:DATA_W];

    always_comb begin
        res_hi = prod[2*DATA_W-1:DATA_W];
        res_lo = prod[DATA_W-1:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = rs_orig;
                res_lo = '1;
            end else begin
                res_hi = neg_r ? -rem : rem;
                res_lo = neg_q ? -quo : quo;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: state_nxt = accept ? ST_RUN : ST_IDLE;
            ST_RUN:           if (cnt == LAST_CNT) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            rs_orig  <= '0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt      <= '0;
                is_div   <= op_div;
                neg_q    <= rs_neg ^ rt_neg;
                neg_r    <= rs_neg;
                div_zero <= op_div && (rt_data_i == '0);
                rs_orig  <= rs_data_i;
            end else if (busy) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (last_step) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (!busy && !accept) begin
                if (mthi_i) hi <= wdata_i;
                if (mtlo_i) lo <= wdata_i;
            end
        end
    end

    assign busy_o     = busy;
    assign done_o     = (state == ST_DONE);
    assign div_zero_o = (state == ST_DONE) && div_zero;
    assign hi_o       = hi;
    assign lo_o       = lo;

endmodule
